// File: rtl/store_output_port_if.sv
// Handshake bundle for store_output_port: CPU store snoop inputs plus the
// valid/ready stream toward the external consumer.
interface store_output_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int OFF_W  = 4
);
  logic              mw;
  logic [ADDR_W-1:0] mw_addr;
  logic [DATA_W-1:0] mw_data;
  logic              out_valid;
  logic              out_ready;
  logic [OFF_W-1:0]  out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mw, mw_addr, mw_data, out_ready,
    input  out_valid, out_addr, out_data
  );

  modport slave (
    input  mw, mw_addr, mw_data, out_ready,
    output out_valid, out_addr, out_data
  );
endinterface

// File: rtl/store_output_port.sv
// Memory-mapped output port: captures CPU stores into an I/O window, queues them
// in a first-word-fall-through FIFO and keeps a last-value register for LEDs.
// Optional drop counter output enabled by defining STORE_PORT_DROP_CNT_EN.
module store_output_port #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 16,
  parameter logic [ADDR_W-1:0] PORT_BASE = 8'hF0,
  parameter logic [ADDR_W-1:0] PORT_MASK = 8'hF0,
  parameter int              DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  store_output_port_if.slave       bus,
  input  logic                     i_ovf_clr,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
`ifdef STORE_PORT_DROP_CNT_EN
  output logic [7:0]               o_drop_cnt,
`endif
  output logic [DATA_W-1:0]        o_led_value
);

  function automatic int mask_ones();
    int n;
    n = 0;
    for (int i = 0; i < ADDR_W; i++) if (PORT_MASK[i]) n++;
    return n;
  endfunction

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int OFF_W   = ADDR_W - mask_ones();
  localparam int ENTRY_W = OFF_W + DATA_W;

  // Packs the address bits outside the mask, LSB first, into the offset field.
  function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    logic [OFF_W-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (!PORT_MASK[i]) begin
        r[j] = a[i];
        j++;
      end
    end
    return r;
  endfunction

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic [DATA_W-1:0]  r_led;
  logic               r_out_valid;
  logic [OFF_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]  r_out_data;

  logic               w_hit;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_entry;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [ENTRY_W-1:0] w_head_nxt;

  always_comb begin
    w_hit        = bus.mw & ((bus.mw_addr & PORT_MASK) == PORT_BASE);
    w_full       = (r_level == LVL_W'(DEPTH));
    w_pop        = r_out_valid & bus.out_ready;
    w_push       = w_hit & (~w_full | w_pop);
    w_drop       = w_hit & w_full & ~w_pop;
    w_entry      = {addr_offset(bus.mw_addr), bus.mw_data};
    w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_level_nxt  = r_level;
    if (w_push && !w_pop) w_level_nxt = r_level + LVL_W'(1);
    if (w_pop && !w_push) w_level_nxt = r_level - LVL_W'(1);
    // The incoming entry becomes head when it lands in the slot the head pointer moves to.
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = w_entry;
    else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_level_nxt == '0) w_head_nxt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_led       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
      if (w_hit) r_led <= bus.mw_data;
      r_out_valid <= (w_level_nxt != '0);
      r_out_addr  <= w_head_nxt[ENTRY_W-1:DATA_W];
      r_out_data  <= w_head_nxt[DATA_W-1:0];
    end
  end

`ifdef STORE_PORT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (i_ovf_clr) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign o_level       = r_level;
  assign o_overflow    = r_overflow;
  assign o_led_value   = r_led;

endmodule

// File: tb/tb_store_output_port.sv
// Directed self-checking bench for store_output_port at default parameters.
module tb_store_output_port;
  logic        clk;
  logic        rst;
  logic        ovf_clr;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] led_value;
`ifdef STORE_PORT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  store_output_port_if #(.ADDR_W(8), .DATA_W(16), .OFF_W(4)) bus_if ();

  store_output_port dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus_if),
    .i_ovf_clr   (ovf_clr),
    .o_level     (level),
    .o_overflow  (overflow),
`ifdef STORE_PORT_DROP_CNT_EN
    .o_drop_cnt  (drop_cnt),
`endif
    .o_led_value (led_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [7:0] a, input logic [15:0] d);
    bus_if.mw      = 1'b1;
    bus_if.mw_addr = a;
    bus_if.mw_data = d;
    tick();
    bus_if.mw      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", bus_if.out_valid); end
    n_checks++; if (bus_if.out_data !== 16'h0) begin n_errors++; $display("FAIL reset_data got=%h exp=0000", bus_if.out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (led_value !== 16'h0) begin n_errors++; $display("FAIL reset_led got=%h exp=0000", led_value); end
  endtask

  task automatic test_single_hit();
    hit(8'hF3, 16'h1234);
    n_checks++; if (bus_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got=%b exp=1", bus_if.out_valid); end
    n_checks++; if (bus_if.out_addr !== 4'h3) begin n_errors++; $display("FAIL single_addr got=%h exp=3", bus_if.out_addr); end
    n_checks++; if (bus_if.out_data !== 16'h1234) begin n_errors++; $display("FAIL single_data got=%h exp=1234", bus_if.out_data); end
    n_checks++; if (level !== 3'd1) begin n_errors++; $display("FAIL single_level got=%0d exp=1", level); end
    n_checks++; if (led_value !== 16'h1234) begin n_errors++; $display("FAIL single_led got=%h exp=1234", led_value); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h1234 || bus_if.out_addr !== 4'h3) begin
        n_errors++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h/%h exp=1/3/1234", i, bus_if.out_valid, bus_if.out_addr, bus_if.out_data);
      end
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL pop_level got=%0d exp=0", level); end
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL pop_valid got=%b exp=0", bus_if.out_valid); end
  endtask

  task automatic test_non_hit();
    hit(8'h20, 16'hBEEF);
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL nonhit_level got=%0d exp=0", level); end
    n_checks++; if (led_value !== 16'h1234) begin n_errors++; $display("FAIL nonhit_led got=%h exp=1234", led_value); end
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL nonhit_valid got=%b exp=0", bus_if.out_valid); end
    bus_if.mw_addr = 8'hF0;
    bus_if.mw_data = 16'h5555;
    tick();
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL mw0_level got=%0d exp=0", level); end
    n_checks++; if (led_value !== 16'h1234) begin n_errors++; $display("FAIL mw0_led got=%h exp=1234", led_value); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) hit(8'hF0 + 8'(i), 16'(i + 1));
    n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL fill_level got=%0d exp=4", level); end
    hit(8'hF4, 16'h0005);
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL drop_ovf got=%b exp=1", overflow); end
    n_checks++; if (led_value !== 16'h0005) begin n_errors++; $display("FAIL drop_led got=%h exp=0005", led_value); end
    n_checks++; if (bus_if.out_data !== 16'h0001) begin n_errors++; $display("FAIL drop_head got=%h exp=0001", bus_if.out_data); end
    n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL drop_level got=%0d exp=4", level); end
`ifdef STORE_PORT_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 8'd1) begin n_errors++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
`ifdef STORE_PORT_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 8'd0) begin n_errors++; $display("FAIL drop_cnt_clr got=%0d exp=0", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    hit(8'hF7, 16'h0007);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL clr_vs_drop got=%b exp=1", overflow); end
`ifdef STORE_PORT_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 8'd1) begin n_errors++; $display("FAIL drop_cnt_clr_drop got=%0d exp=1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr2 got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_d [4];
    logic [3:0]  exp_a [4];
    exp_d = '{16'h0002, 16'h0003, 16'h0004, 16'h0006};
    exp_a = '{4'h1, 4'h2, 4'h3, 4'h5};
    bus_if.out_ready = 1'b1;
    hit(8'hF5, 16'h0006);
    n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL fpp_level got=%0d exp=4", level); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_d[i] || bus_if.out_addr !== exp_a[i]) begin
        n_errors++;
        $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", i, bus_if.out_valid, bus_if.out_addr, bus_if.out_data, exp_a[i], exp_d[i]);
      end
      tick();
    end
    bus_if.out_ready = 1'b0;
    n_checks++; if (level !== 3'd0 || bus_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got=%0d/%b exp=0/0", level, bus_if.out_valid); end
  endtask

  task automatic test_level1_push_pop();
    hit(8'hF8, 16'h0011);
    bus_if.out_ready = 1'b1;
    hit(8'hF9, 16'h0022);
    bus_if.out_ready = 1'b0;
    n_checks++; if (level !== 3'd1) begin n_errors++; $display("FAIL l1_level got=%0d exp=1", level); end
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h0022 || bus_if.out_addr !== 4'h9) begin
      n_errors++;
      $display("FAIL l1_head got=%b/%h/%h exp=1/9/0022", bus_if.out_valid, bus_if.out_addr, bus_if.out_data);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL l1_drain got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    hit(8'hF0, 16'h000A);
    hit(8'hF1, 16'h000B);
    hit(8'hF2, 16'h000C);
    n_checks++; if (level !== 3'd3) begin n_errors++; $display("FAIL mid_pre_level got=%0d exp=3", level); end
    rst = 1'b1;
    hit(8'hF3, 16'h00CC);
    rst = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid got=%b exp=0", bus_if.out_valid); end
    n_checks++; if (led_value !== 16'h0) begin n_errors++; $display("FAIL mid_led got=%h exp=0000", led_value); end
    hit(8'hF1, 16'h00AA);
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h00AA || bus_if.out_addr !== 4'h1) begin
      n_errors++;
      $display("FAIL mid_head got=%b/%h/%h exp=1/1/00aa", bus_if.out_valid, bus_if.out_addr, bus_if.out_data);
    end
    n_checks++; if (level !== 3'd1) begin n_errors++; $display("FAIL mid_post_level got=%0d exp=1", level); end
    n_checks++; if (led_value !== 16'h00AA) begin n_errors++; $display("FAIL mid_post_led got=%h exp=00aa", led_value); end
  endtask

  initial begin
    rst              = 1'b1;
    ovf_clr          = 1'b0;
    bus_if.mw        = 1'b0;
    bus_if.mw_addr   = 8'h00;
    bus_if.mw_data   = 16'h0000;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_non_hit();
    test_overflow();
    test_full_push_pop();
    test_level1_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
